// File: rtl/proc_pkg.sv
// Shared datapath constants and skid-buffer state encoding for the result demux.
package proc_pkg;

    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/demux_skid.sv
// Two-entry skid buffer: registered head/skid words, occupancy FSM and a registered space flag.
module demux_skid
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              space,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    buf_state_e        state, state_nxt;
    logic [DATA_W-1:0] head, head_nxt;
    logic [DATA_W-1:0] skid, skid_nxt;
    logic              pop;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = head;
    assign pop       = out_valid && out_ready;

    // space is registered from the next state so in_ready never depends on out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            head  <= '0;
            skid  <= '0;
            space <= 1'b1;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            skid  <= skid_nxt;
            space <= (state_nxt != ST_TWO);
        end
    end

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_nxt = ST_ONE;
                    head_nxt  = push_data;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    state_nxt = ST_TWO;
                    skid_nxt  = push_data;
                end else if (pop && !push) begin
                    state_nxt = ST_EMPTY;
                end else if (push && pop) begin
                    head_nxt  = push_data;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_nxt = ST_ONE;
                    head_nxt  = skid;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

endmodule

// File: rtl/result_demux.sv
// 1:2 result demultiplexer with a skid buffer per sink.
// Optional saturating delivery counters under `RESULT_DEMUX_STATS_EN.
module result_demux
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
`ifdef RESULT_DEMUX_STATS_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [DATA_W-1:0] b_data
`ifdef RESULT_DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
`endif
);

    logic space_a, space_b;
    logic push_a, push_b;

    assign in_ready = in_sel ? space_b : space_a;
    assign push_a   = in_valid && in_ready && !in_sel;
    assign push_b   = in_valid && in_ready &&  in_sel;

    demux_skid #(.DATA_W(DATA_W)) u_skid_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .space     (space_a),
        .out_valid (a_valid),
        .out_ready (a_ready),
        .out_data  (a_data)
    );

    demux_skid #(.DATA_W(DATA_W)) u_skid_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .space     (space_b),
        .out_valid (b_valid),
        .out_ready (b_ready),
        .out_data  (b_data)
    );

`ifdef RESULT_DEMUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_valid && a_ready && (cnt_a != '1)) cnt_a <= cnt_a + 1'b1;
            if (b_valid && b_ready && (cnt_b != '1)) cnt_b <= cnt_b + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_result_demux.sv
// Directed self-checking bench for result_demux; stats checks compile in with RESULT_DEMUX_STATS_EN.
module tb_result_demux;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_sel;
    logic [DW-1:0] in_data;
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] b_data;

    int total = 0;
    int bad   = 0;

`ifdef RESULT_DEMUX_STATS_EN
    logic [15:0]   cnt_a, cnt_b;
    logic [1:0]    cnt2_a, cnt2_b;
    logic          in_ready2, a_valid2, b_valid2;
    logic [DW-1:0] a_data2, b_data2;

    result_demux #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    result_demux #(.DATA_W(DW), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_sel(in_sel), .in_data(in_data),
        .a_valid(a_valid2), .a_ready(a_ready), .a_data(a_data2),
        .b_valid(b_valid2), .b_ready(b_ready), .b_data(b_data2),
        .cnt_a(cnt2_a), .cnt_b(cnt2_b)
    );
`else
    result_demux #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_sel = 1'b1; in_data = 32'h33;
        tick();
        in_valid = 1'b0;
        total++;
        if (a_valid !== 1'b1 || b_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_prefill: got a_valid=%b b_valid=%b want 1 1", a_valid, b_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid: got %b want 0", a_valid); end
        total++;
        if (b_valid !== 1'b0) begin bad++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
        total++;
        if (a_data !== 32'h0 || b_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got a=%h b=%h want 0 0", a_data, b_data);
        end
        in_sel = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_a: got %b want 1", in_ready); end
        in_sel = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_b: got %b want 1", in_ready); end
`ifdef RESULT_DEMUX_STATS_EN
        total++;
        if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
            bad++;
            $display("FAIL reset_counters: got a=%0d b=%0d want 0 0", cnt_a, cnt_b);
        end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_sel = 1'b0;
    endtask

    task automatic test_single();
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; in_data = 32'h0;
        total++;
        if (a_valid !== 1'b1 || a_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_a: got valid=%b data=%h want 1 deadbeef", a_valid, a_data);
        end
        total++;
        if (b_valid !== 1'b0) begin bad++; $display("FAIL single_b_valid: got %b want 0", b_valid); end
        tick();
        total++;
        if (a_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", a_valid); end
    endtask

    task automatic test_backpressure();
        a_ready = 1'b0; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept1: got %b want 1", in_ready); end
        tick();
        in_data = 32'h2;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept2: got %b want 1", in_ready); end
        tick();
        in_data = 32'h3;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall3: got %b want 0", in_ready); end
        tick();
        total++;
        if (a_valid !== 1'b1 || a_data !== 32'h1) begin
            bad++;
            $display("FAIL bp_hold: got valid=%b data=%h want 1 1", a_valid, a_data);
        end
        a_ready = 1'b1;
        tick();
        total++;
        if (a_data !== 32'h2) begin bad++; $display("FAIL bp_order2: got %h want 2", a_data); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_resume: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++;
        if (a_valid !== 1'b1 || a_data !== 32'h3) begin
            bad++;
            $display("FAIL bp_order3: got valid=%b data=%h want 1 3", a_valid, a_data);
        end
        tick();
        total++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty: got a=%b b=%b want 0 0", a_valid, b_valid);
        end
    endtask

    task automatic test_throughput();
        logic sel;
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel      = (i % 2) == 1;
            in_valid = 1'b1; in_sel = sel; in_data = DW'(i);
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL tput_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            total++;
            if (a_valid !== !sel || b_valid !== sel) begin
                bad++;
                $display("FAIL tput_valid[%0d]: got a=%b b=%b want %b %b", i, a_valid, b_valid, !sel, sel);
            end
            total++;
            if ((sel ? b_data : a_data) !== DW'(i)) begin
                bad++;
                $display("FAIL tput_data[%0d]: got %h want %h", i, sel ? b_data : a_data, i);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_head_of_line();
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA1;
        tick();
        in_data = 32'hA2;
        tick();
        in_data = 32'hA3;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL hol_stall: got %b want 0", in_ready); end
        tick();
        tick();
        total++;
        if (b_valid !== 1'b0) begin bad++; $display("FAIL hol_b_empty: got %b want 0", b_valid); end
        total++;
        if (a_data !== 32'hA1) begin bad++; $display("FAIL hol_a_head: got %h want a1", a_data); end
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hB1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL hol_b_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++;
        if (b_valid !== 1'b1 || b_data !== 32'hB1) begin
            bad++;
            $display("FAIL hol_b_accept: got valid=%b data=%h want 1 b1", b_valid, b_data);
        end
        a_ready = 1'b1; b_ready = 1'b1;
        tick();
        total++;
        if (a_data !== 32'hA2 || b_valid !== 1'b0) begin
            bad++;
            $display("FAIL hol_drain: got a=%h b_valid=%b want a2 0", a_data, b_valid);
        end
        tick();
    endtask

    task automatic test_idle();
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b0; in_sel = 1'b1; in_data = 32'hFFFF0000;
        tick();
        in_sel = 1'b0;
        tick();
        total++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_push: got a=%b b=%b want 0 0", a_valid, b_valid);
        end
    endtask

`ifdef RESULT_DEMUX_STATS_EN
    task automatic test_stats();
        logic [7:0] sels;
        sels = 8'b1110_0000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = sels[i]; in_data = DW'(i + 100);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        total++;
        if (cnt_a !== 16'd5 || cnt_b !== 16'd3) begin
            bad++;
            $display("FAIL stats_counts: got a=%0d b=%0d want 5 3", cnt_a, cnt_b);
        end
        total++;
        if (cnt2_a !== 2'd3 || cnt2_b !== 2'd3) begin
            bad++;
            $display("FAIL stats_saturate: got a=%0d b=%0d want 3 3", cnt2_a, cnt2_b);
        end
        total++;
        if (a_valid2 !== 1'b0 || b_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
            bad++;
            $display("FAIL stats_narrow_idle: got a=%b b=%b rdy=%b want 0 0 1", a_valid2, b_valid2, in_ready2);
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        test_reset();
        test_single();
        test_backpressure();
        test_throughput();
        test_head_of_line();
        test_idle();
`ifdef RESULT_DEMUX_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
